// File: rtl/prog_sequencer.sv
// prog_sequencer: loads a program into instruction memory, then releases the
// core from reset and watches its PC until it halts or the cycle budget ends.
//
// Ports:
//   CLK, RESET_N        clock, asynchronous active-low reset
//   start               one-cycle request to begin a load-and-run session
//   load_valid/data/last  program word stream; load_ready accepts a word
//   imem_we/waddr/wdata instruction-memory write port
//   core_rst_n          active-low reset to the core, high only while running
//   iaddr               core PC, observed for halt detection
//   busy/done/timeout   session status (LOAD|RUN / HALTED / TIMEOUT)
//   cycles              RUN cycles elapsed in the current session
//   words_loaded        words written in the current session
module prog_sequencer #(
  parameter int ADDR_WIDTH  = 10,
  parameter int SIZE        = 32,
  parameter int MAX_CYCLES  = 1000,
  parameter int HALT_REPEAT = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic                  load_valid,
  input  logic [SIZE-1:0]       load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [SIZE-1:0]       imem_wdata,
  output logic                  core_rst_n,
  input  logic [ADDR_WIDTH-1:0] iaddr,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [15:0]           cycles,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_HALTED  = 3'd3;
  localparam logic [2:0] S_TIMEOUT = 3'd4;

  // Halt counter only needs to count up to HALT_REPEAT.
  localparam int              HCW        = $clog2(HALT_REPEAT + 1);
  localparam logic [HCW:0]    HALT_LIM   = (HCW + 1)'(HALT_REPEAT);
  localparam logic [16:0]     CYC_LIM    = 17'(MAX_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] WPTR_LAST = '1;
  localparam logic [ADDR_WIDTH:0]   WORD_ONE  = (ADDR_WIDTH + 1)'(1);

  logic [2:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] wptr_reg, wptr_next;
  logic [ADDR_WIDTH:0]   words_reg, words_next;
  logic [15:0]           cycles_reg, cycles_next;
  logic [HCW-1:0]        halt_cnt_reg, halt_cnt_next;
  logic [ADDR_WIDTH-1:0] prev_pc_reg;
  logic                  load_ready_reg;
  logic                  core_rst_n_reg;

  logic                  handshake;
  logic                  pc_match;
  logic [16:0]           cyc_inc;
  logic [HCW:0]          halt_inc;

  assign handshake  = load_valid & load_ready_reg;
  assign imem_we    = handshake;
  assign imem_waddr = wptr_reg;
  assign imem_wdata = load_data;

  assign cyc_inc  = {1'b0, cycles_reg} + 17'd1;
  assign halt_inc = {1'b0, halt_cnt_reg} + {{HCW{1'b0}}, 1'b1};
  // cycles is still zero on the first RUN cycle, so no comparison is made then.
  assign pc_match = (cycles_reg != 16'd0) && (iaddr == prev_pc_reg);

  always_comb begin
    state_next    = state_reg;
    wptr_next     = wptr_reg;
    words_next    = words_reg;
    cycles_next   = cycles_reg;
    halt_cnt_next = halt_cnt_reg;
    case (state_reg)
      S_IDLE, S_HALTED, S_TIMEOUT: begin
        if (start) begin
          state_next    = S_LOAD;
          wptr_next     = '0;
          words_next    = '0;
          cycles_next   = '0;
          halt_cnt_next = '0;
        end
      end
      S_LOAD: begin
        if (handshake) begin
          words_next = words_reg + WORD_ONE;
          if (load_last || (wptr_reg == WPTR_LAST)) begin
            state_next = S_RUN;
          end
          // A full memory leaves the pointer on the last address.
          if (wptr_reg != WPTR_LAST) begin
            wptr_next = wptr_reg + 1'b1;
          end
        end
      end
      S_RUN: begin
        cycles_next   = cyc_inc[15:0];
        halt_cnt_next = pc_match ? halt_inc[HCW-1:0] : '0;
        // Halt takes priority over a coincident timeout.
        if (pc_match && (halt_inc == HALT_LIM)) begin
          state_next = S_HALTED;
        end else if (cyc_inc == CYC_LIM) begin
          state_next = S_TIMEOUT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg      <= S_IDLE;
      wptr_reg       <= '0;
      words_reg      <= '0;
      cycles_reg     <= '0;
      halt_cnt_reg   <= '0;
      prev_pc_reg    <= '0;
      load_ready_reg <= 1'b0;
      core_rst_n_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wptr_reg       <= wptr_next;
      words_reg      <= words_next;
      cycles_reg     <= cycles_next;
      halt_cnt_reg   <= halt_cnt_next;
      prev_pc_reg    <= iaddr;
      // Registered decodes of the next state keep these glitch-free.
      load_ready_reg <= (state_next == S_LOAD);
      core_rst_n_reg <= (state_next == S_RUN);
    end
  end

  assign load_ready   = load_ready_reg;
  assign core_rst_n   = core_rst_n_reg;
  assign busy         = (state_reg == S_LOAD) || (state_reg == S_RUN);
  assign done         = (state_reg == S_HALTED);
  assign timeout      = (state_reg == S_TIMEOUT);
  assign cycles       = cycles_reg;
  assign words_loaded = words_reg;

endmodule
